// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART core (baud generator, TX, RX).
//   OVERSAMPLE_DEFAULT : oversample ticks per bit period
//   DIV_WIDTH_DEFAULT  : width of the baud divisor
//   div_t              : divisor type at the default width
//   os_bits()          : width of an oversample phase counter
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DIV_WIDTH_DEFAULT  = 16;

  typedef logic [DIV_WIDTH_DEFAULT-1:0] div_t;

  function automatic int os_bits(input int oversample);
    return $clog2(oversample);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// mod_counter: modulus counter with enable, synchronous clear and a
// runtime modulus.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   en    : advance the count this cycle
//   clr   : synchronous clear, overrides en
//   last  : terminal count (modulus - 1)
//   count : current count
//   wrap  : combinational strobe, high on the cycle count wraps to 0
module mod_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         wrap
);

  // A clear suppresses the wrap so no downstream stage sees a stray strobe.
  assign wrap = en && !clr && (count == last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (wrap) count <= '0;
      else      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: runtime-programmable baud tick generator.
//   in       : system clock, rising edge
//   rst      : asynchronous active-high reset
//   en       : count enable
//   sync     : realign phase, clears both counters
//   div      : new divisor value
//   div_load : load div into the divisor register (also clears counters)
//   os_tick  : one-cycle oversample strobe, every max(div,1) cycles
//   bit_tick : one-cycle strobe per bit period
//   mid_tick : one-cycle strobe at bit centre
//   count    : prescale count
//   os_count : oversample phase
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int WIDTH       = DIV_WIDTH_DEFAULT,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
  parameter int DEFAULT_DIV = 27
) (
  input  logic                          in,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          sync,
  input  logic [WIDTH-1:0]              div,
  input  logic                          div_load,
  output logic                          os_tick,
  output logic                          bit_tick,
  output logic                          mid_tick,
  output logic [WIDTH-1:0]              count,
  output logic [$clog2(OVERSAMPLE)-1:0] os_count
);

  localparam int OSW = os_bits(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
  // mid_tick fires on the step into phase OVERSAMPLE/2.
  localparam logic [OSW-1:0] MID_LAST = OSW'(OVERSAMPLE / 2 - 1);

  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] pre_last;
  logic             clr;
  logic             pre_wrap;
  logic             os_wrap;

  // A divisor of 0 behaves as 1, so both 0 and 1 give a terminal count of 0.
  assign pre_last = (div_r == '0) ? '0 : div_r - WIDTH'(1);
  assign clr      = sync || div_load;

  mod_counter #(.W(WIDTH)) u_prescale (
    .clk   (in),
    .rst   (rst),
    .en    (en),
    .clr   (clr),
    .last  (pre_last),
    .count (count),
    .wrap  (pre_wrap)
  );

  mod_counter #(.W(OSW)) u_oversample (
    .clk   (in),
    .rst   (rst),
    .en    (pre_wrap),
    .clr   (clr),
    .last  (OS_LAST),
    .count (os_count),
    .wrap  (os_wrap)
  );

  always_ff @(posedge in or posedge rst) begin
    if (rst) begin
      div_r    <= WIDTH'(DEFAULT_DIV);
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
    end else begin
      if (div_load) div_r <= div;
      // pre_wrap is already gated by en and by a clear, so ticks drop
      // automatically on the cycle after en=0, sync or div_load.
      os_tick  <= pre_wrap;
      bit_tick <= os_wrap;
      mid_tick <= pre_wrap && (os_count == MID_LAST);
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: directed test of baud_tick_gen (DEFAULT_DIV=4,
// OVERSAMPLE=4). A model counts enabled cycles since the last clear and
// derives every output arithmetically; a negedge process compares the DUT
// against it each cycle, and literal checks pin the model to hand-computed
// values along the way.
module tb_baud_tick_gen;

  localparam int W   = 16;
  localparam int OS  = 4;
  localparam int DEF = 4;

  logic         clk      = 1'b0;
  logic         rst      = 1'b1;
  logic         en       = 1'b0;
  logic         sync     = 1'b0;
  logic [W-1:0] div      = '0;
  logic         div_load = 1'b0;
  logic         os_tick, bit_tick, mid_tick;
  logic [W-1:0] count;
  logic [1:0]   os_count;

  int checks   = 0;
  int failures = 0;

  baud_tick_gen #(.WIDTH(W), .OVERSAMPLE(OS), .DEFAULT_DIV(DEF)) dut (
    .in       (clk),
    .rst      (rst),
    .en       (en),
    .sync     (sync),
    .div      (div),
    .div_load (div_load),
    .os_tick  (os_tick),
    .bit_tick (bit_tick),
    .mid_tick (mid_tick),
    .count    (count),
    .os_count (os_count)
  );

  always #5 clk = ~clk;

  // Model: n = enabled edges since the last clear, adv = last edge advanced n.
  int n      = 0;
  int m_div  = DEF;
  bit adv    = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0; m_div = DEF; adv = 1'b0;
    end else if (div_load) begin
      m_div = int'(div); n = 0; adv = 1'b0;
    end else if (sync) begin
      n = 0; adv = 1'b0;
    end else if (en) begin
      n = n + 1; adv = 1'b1;
    end else begin
      adv = 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    int mm, e_cnt, e_os, e_ost, e_bit, e_mid;
    mm    = (m_div == 0) ? 1 : m_div;
    e_cnt = n % mm;
    e_os  = (n / mm) % OS;
    e_ost = (adv && (n % mm == 0)) ? 1 : 0;
    e_bit = (e_ost == 1 && e_os == 0) ? 1 : 0;
    e_mid = (e_ost == 1 && e_os == OS / 2) ? 1 : 0;
    chk("model_count",    int'(count),    e_cnt);
    chk("model_os_count", int'(os_count), e_os);
    chk("model_os_tick",  int'(os_tick),  e_ost);
    chk("model_bit_tick", int'(bit_tick), e_bit);
    chk("model_mid_tick", int'(mid_tick), e_mid);
    $display("cyc n=%0d m=%0d count=%0d os_count=%0d os=%0d bit=%0d mid=%0d",
             n, mm, count, os_count, os_tick, bit_tick, mid_tick);
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic load(input int d);
    div = W'(d); div_load = 1'b1;
    step(1);
    div_load = 1'b0;
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_count", int'(count), 0);
    chk("rst_os_count", int'(os_count), 0);
    chk("rst_os_tick", int'(os_tick), 0);
    rst = 1'b0; en = 1'b1;

    // First os_tick after the 4th edge, mid at edge 8, bit at edge 16
    step(3);
    chk("pre_first_count", int'(count), 3);
    chk("pre_first_os_tick", int'(os_tick), 0);
    step(1);
    chk("first_os_tick", int'(os_tick), 1);
    chk("first_os_count", int'(os_count), 1);
    step(4);
    chk("first_mid_tick", int'(mid_tick), 1);
    step(8);
    chk("first_bit_tick", int'(bit_tick), 1);
    chk("first_bit_os_count", int'(os_count), 0);

    // Hold with en low at count=2
    step(2);
    chk("hold_start_count", int'(count), 2);
    en = 1'b0;
    step(5);
    chk("hold_count", int'(count), 2);
    chk("hold_os_tick", int'(os_tick), 0);
    en = 1'b1;
    step(1);
    chk("resume_no_tick", int'(os_tick), 0);
    step(1);
    chk("resume_os_tick", int'(os_tick), 1);

    // Divisor 0 behaves as 1
    load(0);
    chk("div0_clear_tick", int'(os_tick), 0);
    step(1);
    chk("div0_os_tick", int'(os_tick), 1);
    step(1);
    chk("div0_os_tick2", int'(os_tick), 1);
    load(1);
    step(3);
    chk("div1_no_bit", int'(bit_tick), 0);
    step(1);
    chk("div1_bit_tick", int'(bit_tick), 1);

    // Load 6 while count=3
    load(4);
    step(3);
    chk("pre_load6_count", int'(count), 3);
    load(6);
    chk("load6_count", int'(count), 0);
    chk("load6_os_count", int'(os_count), 0);
    step(5);
    chk("load6_count5", int'(count), 5);
    chk("load6_no_tick", int'(os_tick), 0);
    step(1);
    chk("load6_os_tick", int'(os_tick), 1);
    step(6);
    chk("load6_os_tick2", int'(os_tick), 1);

    // sync at os_count=3 with m=4
    load(4);
    step(12);
    chk("pre_sync_os_count", int'(os_count), 3);
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    chk("sync_os_count", int'(os_count), 0);
    chk("sync_count", int'(count), 0);
    step(7);
    chk("sync_no_mid", int'(mid_tick), 0);
    step(1);
    chk("sync_mid_tick", int'(mid_tick), 1);
    step(8);
    chk("sync_bit_tick", int'(bit_tick), 1);

    // div_load and sync together, then div_load with en low
    div = W'(5); div_load = 1'b1; sync = 1'b1;
    step(1);
    div_load = 1'b0; sync = 1'b0;
    step(5);
    chk("load_sync_os_tick", int'(os_tick), 1);
    en = 1'b0;
    load(2);
    chk("load_en0_count", int'(count), 0);
    en = 1'b1;
    step(2);
    chk("load_en0_os_tick", int'(os_tick), 1);

    // Async reset mid-cycle while a tick is high; divisor returns to 4
    load(3);
    step(3);
    chk("pre_arst_os_tick", int'(os_tick), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_os_tick", int'(os_tick), 0);
    chk("arst_count", int'(count), 0);
    rst = 1'b0;
    step(3);
    chk("post_arst_no_tick", int'(os_tick), 0);
    step(1);
    chk("post_arst_os_tick", int'(os_tick), 1);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
